// File: rtl/reaction_timer_ctrl.sv
// Reaction-timer round sequencer: counts out a random delay in ms, lights the
// stimulus LED, then measures the player's response time or flags a timeout.
//
// state      | meaning
// -----------+--------------------------------------------------------------
// IDLE       | waiting for start; last result and flags held on the outputs
// WAIT_DELAY | counting the sampled random delay down, one ms per tick
// ARMED      | LED lit, counting reaction time up until react or timeout
module reaction_timer_ctrl #(
  parameter int CLKS_PER_MS = 50000,
  parameter int RAND_WIDTH  = 11,
  parameter int TIME_WIDTH  = 14,
  parameter int TIMEOUT_MS  = 9999
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  react,
  input  logic [RAND_WIDTH-1:0] random_value,
  output logic                  led_on,
  output logic                  busy,
  output logic [TIME_WIDTH-1:0] time_ms,
  output logic                  time_valid,
  output logic                  false_start,
  output logic                  timeout
);

  localparam int PRE_WIDTH = $clog2(CLKS_PER_MS);
  localparam logic [PRE_WIDTH-1:0]  PRE_LAST    = PRE_WIDTH'(CLKS_PER_MS - 1);
  localparam logic [PRE_WIDTH-1:0]  PRE_ONE     = PRE_WIDTH'(1);
  localparam logic [RAND_WIDTH-1:0] DELAY_ONE   = RAND_WIDTH'(1);
  localparam logic [TIME_WIDTH-1:0] CNT_ONE     = TIME_WIDTH'(1);
  localparam logic [TIME_WIDTH-1:0] CNT_TIMEOUT = TIME_WIDTH'(TIMEOUT_MS);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_DELAY,
    ARMED
  } state_t;

  state_t                state;
  logic [PRE_WIDTH-1:0]  prescaler;
  logic [RAND_WIDTH-1:0] delay;
  logic [TIME_WIDTH-1:0] react_cnt;
  logic                  tick;

  assign tick = (prescaler == PRE_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      prescaler   <= '0;
      delay       <= '0;
      react_cnt   <= '0;
      led_on      <= 1'b0;
      busy        <= 1'b0;
      time_ms     <= '0;
      time_valid  <= 1'b0;
      false_start <= 1'b0;
      timeout     <= 1'b0;
    end else begin
      // Wrapping on the tick also gives the zeroed prescaler on ARMED entry.
      prescaler <= tick ? '0 : prescaler + PRE_ONE;

      case (state)
        IDLE: begin
          prescaler <= '0;
          if (start) begin
            delay       <= (random_value == '0) ? DELAY_ONE : random_value;
            time_ms     <= '0;
            time_valid  <= 1'b0;
            false_start <= 1'b0;
            timeout     <= 1'b0;
            busy        <= 1'b1;
            state       <= WAIT_DELAY;
          end
        end

        WAIT_DELAY: begin
          if (react) begin
            false_start <= 1'b1;
            busy        <= 1'b0;
            state       <= IDLE;
          end else if (tick) begin
            delay <= delay - DELAY_ONE;
            if (delay == DELAY_ONE) begin
              led_on    <= 1'b1;
              react_cnt <= '0;
              state     <= ARMED;
            end
          end
        end

        ARMED: begin
          if (react) begin
            time_ms    <= react_cnt;
            time_valid <= 1'b1;
            led_on     <= 1'b0;
            busy       <= 1'b0;
            state      <= IDLE;
          end else if (tick) begin
            if (react_cnt + CNT_ONE == CNT_TIMEOUT) begin
              time_ms    <= CNT_TIMEOUT;
              timeout    <= 1'b1;
              time_valid <= 1'b1;
              led_on     <= 1'b0;
              busy       <= 1'b0;
              state      <= IDLE;
            end else begin
              react_cnt <= react_cnt + CNT_ONE;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_reaction_timer_ctrl.sv
// Bench for reaction_timer_ctrl: timestamp-based reference model checked every
// cycle, directed round scenarios with literal expectations, then random play.
module tb_reaction_timer_ctrl;

  localparam int CPM = 4;
  localparam int RW  = 11;
  localparam int TW  = 14;
  localparam int TO  = 5;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          react = 1'b0;
  logic [RW-1:0] random_value = '0;
  logic          led_on;
  logic          busy;
  logic [TW-1:0] time_ms;
  logic          time_valid;
  logic          false_start;
  logic          timeout;

  int checks = 0;
  int failures = 0;

  reaction_timer_ctrl #(
    .CLKS_PER_MS(CPM),
    .RAND_WIDTH (RW),
    .TIME_WIDTH (TW),
    .TIMEOUT_MS (TO)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .react       (react),
    .random_value(random_value),
    .led_on      (led_on),
    .busy        (busy),
    .time_ms     (time_ms),
    .time_valid  (time_valid),
    .false_start (false_start),
    .timeout     (timeout)
  );

  always #5 clk = ~clk;

  // Reference model: rounds described by absolute cycle stamps.
  // phase 0 = no round, 1 = waiting for the LED, 2 = LED lit.
  longint cyc = 0;
  longint led_cyc = 0;
  longint arm_cyc = 0;
  int     phase = 0;
  bit     model_ready = 1'b0;
  int     e_led = 0, e_busy = 0, e_tms = 0, e_valid = 0, e_fs = 0, e_to = 0;

  always @(posedge clk) begin
    if (reset) begin
      phase = 0;
      e_led = 0; e_busy = 0; e_tms = 0; e_valid = 0; e_fs = 0; e_to = 0;
      model_ready = 1'b1;
    end else begin
      case (phase)
        0: if (start) begin
          led_cyc = cyc + 1 + longint'((random_value == 0) ? 1 : int'(random_value)) * CPM;
          e_tms = 0; e_valid = 0; e_fs = 0; e_to = 0; e_busy = 1;
          phase = 1;
        end
        1: if (react) begin
          e_fs = 1; e_busy = 0; phase = 0;
        end else if (cyc + 1 == led_cyc) begin
          e_led = 1; arm_cyc = cyc + 1; phase = 2;
        end
        default: if (react) begin
          e_tms = int'((cyc - arm_cyc) / CPM);
          e_valid = 1; e_led = 0; e_busy = 0; phase = 0;
        end else if (cyc == arm_cyc + TO * CPM - 1) begin
          e_tms = TO; e_to = 1; e_valid = 1; e_led = 0; e_busy = 0; phase = 0;
        end
      endcase
    end
    cyc++;
  end

  always @(negedge clk) begin
    if (model_ready) begin
      checks++;
      if (int'(led_on) != e_led || int'(busy) != e_busy || int'(time_ms) != e_tms ||
          int'(time_valid) != e_valid || int'(false_start) != e_fs || int'(timeout) != e_to) begin
        failures++;
        $display("FAIL model_cmp cyc=%0d got led=%0d busy=%0d tms=%0d valid=%0d fs=%0d to=%0d expected led=%0d busy=%0d tms=%0d valid=%0d fs=%0d to=%0d",
                 cyc, led_on, busy, time_ms, time_valid, false_start, timeout,
                 e_led, e_busy, e_tms, e_valid, e_fs, e_to);
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
    end
  endtask

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start(input int rv);
    random_value = RW'(rv);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic pulse_react();
    react = 1'b1;
    @(negedge clk);
    react = 1'b0;
  endtask

  task automatic chk_all_zero(input string name);
    chk(name, int'({led_on, busy, time_valid, false_start, timeout}) + int'(time_ms), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int react_div;
    // Reset held two cycles, stray react ignored.
    wait_n(2);
    reset = 1'b0;
    chk_all_zero("reset_outputs");
    pulse_react();
    wait_n(2);
    chk_all_zero("idle_react_ignored");

    // Delay of 3 ms: busy at N+1, LED exactly at N+13; react at E+10.
    pulse_start(3);
    chk("busy_n1", int'(busy), 1);
    wait_n(11);
    chk("led_early_n12", int'(led_on), 0);
    wait_n(1);
    chk("led_rise_n13", int'(led_on), 1);
    wait_n(10);
    pulse_react();
    chk("react_tms", int'(time_ms), 2);
    chk("model_react_tms", e_tms, 2);
    chk("react_valid", int'(time_valid), 1);
    chk("react_led_off", int'(led_on), 0);
    chk("react_busy_off", int'(busy), 0);
    wait_n(5);
    chk("result_held", int'(time_ms), 2);

    // False start at N+6.
    pulse_start(3);
    wait_n(5);
    pulse_react();
    chk("fs_flag", int'(false_start), 1);
    chk("model_fs_flag", e_fs, 1);
    chk("fs_valid", int'(time_valid), 0);
    chk("fs_busy", int'(busy), 0);
    wait_n(10);
    chk("fs_led_stays_off", int'(led_on), 0);

    // React on the final delay tick (N+12) still counts as a false start.
    pulse_start(3);
    wait_n(11);
    pulse_react();
    chk("fs_final_tick", int'(false_start), 1);
    chk("fs_final_led", int'(led_on), 0);

    // Timeout with delay 1 (E=N+5).
    pulse_start(1);
    wait_n(4);
    chk("to_led_on", int'(led_on), 1);
    wait_n(19);
    chk("to_not_yet", int'(timeout), 0);
    wait_n(1);
    chk("to_flag", int'(timeout), 1);
    chk("to_tms", int'(time_ms), TO);
    chk("to_valid", int'(time_valid), 1);
    chk("to_led_off", int'(led_on), 0);

    // React in the timeout-tick cycle wins with the pre-increment count.
    pulse_start(2);
    wait_n(8);
    chk("e_led_on_d2", int'(led_on), 1);
    wait_n(19);
    pulse_react();
    chk("edge_tms", int'(time_ms), 4);
    chk("model_edge_tms", e_tms, 4);
    chk("edge_timeout", int'(timeout), 0);

    // Value 0 loads as 1 ms; second start while ARMED is ignored.
    pulse_start(0);
    wait_n(3);
    chk("zero_delay_led_early", int'(led_on), 0);
    wait_n(1);
    chk("zero_delay_led", int'(led_on), 1);
    wait_n(2);
    pulse_start(7);
    chk("armed_restart_ignored", int'(led_on), 1);
    wait_n(3);
    pulse_react();
    chk("armed_restart_tms", int'(time_ms), 1);

    // New start clears the result one cycle later; react coinciding with start is ignored.
    random_value = RW'(2);
    start = 1'b1;
    react = 1'b1;
    @(negedge clk);
    start = 1'b0;
    react = 1'b0;
    chk("restart_clears_valid", int'(time_valid), 0);
    chk("restart_clears_tms", int'(time_ms), 0);
    chk("restart_no_fs", int'(false_start), 0);
    wait_n(8);
    chk("led_before_reset", int'(led_on), 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk_all_zero("midround_reset");

    // Random play.
    react_div = 3;
    for (int i = 0; i < 3000; i++) begin
      if (i % 200 == 0) react_div = (i / 200 % 3 == 0) ? 4 : ((i / 200 % 3 == 1) ? 25 : 60);
      start = ($urandom_range(0, 9) == 0);
      react = ($urandom_range(0, react_div - 1) == 0);
      random_value = RW'($urandom_range(0, 8));
      reset = ($urandom_range(0, 399) == 0);
      @(negedge clk);
    end
    start = 1'b0;
    react = 1'b0;
    reset = 1'b0;
    wait_n(5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
